// File: rtl/decoder3_8_seq.sv
// Registered 3-to-8 decoder with a valid/ready code input and a walking-one scan
// sequencer that replays every one-hot pattern for encoder self-check.
module decoder3_8_seq #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] a,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic       start,
  output logic [7:0] y,
  output logic       y_valid,
  output logic       busy,
  output logic       done
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t        state, state_nx;
  logic [2:0]    idx, idx_nx;
  logic [HW-1:0] hcnt, hcnt_nx;
  logic [7:0]    y_nx;
  logic          y_valid_nx;
  logic          done_nx;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 3'd0;
      hcnt    <= HW'(0);
      y       <= 8'h00;
      y_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      hcnt    <= hcnt_nx;
      y       <= y_nx;
      y_valid <= y_valid_nx;
      done    <= done_nx;
    end
  end

  // Next-state and next-output logic; start wins over a simultaneous code
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    hcnt_nx    = hcnt;
    y_nx       = y;
    y_valid_nx = 1'b0;
    done_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx   = SCAN;
          idx_nx     = 3'd0;
          hcnt_nx    = HW'(1);
          y_nx       = 8'h01;
          y_valid_nx = 1'b1;
        end else if (a_valid) begin
          y_nx       = en ? (8'h01 << a) : 8'h00;
          y_valid_nx = 1'b1;
        end
      end
      SCAN: begin
        if (hcnt < HW'(HOLD_CYCLES)) begin
          hcnt_nx = hcnt + HW'(1);
        end else if (idx != 3'd7) begin
          idx_nx     = idx + 3'd1;
          y_nx       = {y[6:0], 1'b0};
          hcnt_nx    = HW'(1);
          y_valid_nx = 1'b1;
        end else begin
          state_nx = IDLE;
          idx_nx   = 3'd0;
          hcnt_nx  = HW'(0);
          y_nx     = 8'h00;
          done_nx  = 1'b1;
        end
      end
    endcase
  end

  assign busy    = (state == SCAN);
  assign a_ready = !busy && !rst;

endmodule

// File: tb/tb_decoder3_8_seq.sv
// Self-checking bench for decoder3_8_seq: two instances (HOLD_CYCLES 4 and 1) with
// scoreboard queues of expected y values popped on every y_valid pulse.
`timescale 1ns/1ps
module tb_decoder3_8_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       en4 = 1'b0, a_valid4 = 1'b0, start4 = 1'b0;
  logic [2:0] a4 = 3'd0;
  logic [7:0] y4;
  logic       y_valid4, a_ready4, busy4, done4;

  logic       en1 = 1'b0, a_valid1 = 1'b0, start1 = 1'b0;
  logic [2:0] a1 = 3'd0;
  logic [7:0] y1;
  logic       y_valid1, a_ready1, busy1, done1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] q4[$];
  logic [7:0] q1[$];

  decoder3_8_seq #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .a(a4), .a_valid(a_valid4), .a_ready(a_ready4),
    .start(start4), .y(y4), .y_valid(y_valid4), .busy(busy4), .done(done4)
  );

  decoder3_8_seq #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .a(a1), .a_valid(a_valid1), .a_ready(a_ready1),
    .start(start1), .y(y1), .y_valid(y_valid1), .busy(busy1), .done(done1)
  );

  // Scoreboard: every y_valid pulse must match the oldest expected value
  always @(negedge clk) begin : sb4
    logic [7:0] e;
    if (y_valid4) begin
      n_tests++;
      if (q4.size() == 0) begin
        n_fail++;
        $display("FAIL sb4: unexpected y_valid, y=%h, expected no output", y4);
      end else begin
        e = q4.pop_front();
        if (y4 !== e) begin
          n_fail++;
          $display("FAIL sb4: y=%h, expected %h", y4, e);
        end
      end
    end
  end

  always @(negedge clk) begin : sb1
    logic [7:0] e;
    if (y_valid1) begin
      n_tests++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL sb1: unexpected y_valid, y=%h, expected no output", y1);
      end else begin
        e = q1.pop_front();
        if (y1 !== e) begin
          n_fail++;
          $display("FAIL sb1: y=%h, expected %h", y1, e);
        end
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({y4, y_valid4, busy4, done4, a_ready4} !== {8'h00, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_hold: {y,yv,busy,done,rdy}=%h, expected %h",
               {y4, y_valid4, busy4, done4, a_ready4}, {8'h00, 4'b0000});
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({y4, y_valid4, busy4, done4, a_ready4} !== {8'h00, 4'b0001}) begin
      n_fail++;
      $display("FAIL reset_release: {y,yv,busy,done,rdy}=%h, expected %h",
               {y4, y_valid4, busy4, done4, a_ready4}, {8'h00, 4'b0001});
    end
  endtask

  task automatic test_direct();
    logic [7:0] e;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = 8'h01 << (i - 1);
        n_tests++;
        if ({y4, y_valid4} !== {e, 1'b1}) begin
          n_fail++;
          $display("FAIL direct_%0d: y=%h yv=%b, expected y=%h yv=1", i - 1, y4, y_valid4, e);
        end
      end
      if (i < 8) begin
        en4 = 1'b1; a4 = 3'(i); a_valid4 = 1'b1;
        q4.push_back(8'h01 << i);
      end else begin
        a_valid4 = 1'b0;
      end
    end
    @(negedge clk);
    n_tests++;
    if ({y4, y_valid4} !== {8'h80, 1'b0}) begin
      n_fail++;
      $display("FAIL direct_hold: y=%h yv=%b, expected y=80 yv=0", y4, y_valid4);
    end
  endtask

  task automatic test_disabled();
    en4 = 1'b0; a4 = 3'd5; a_valid4 = 1'b1;
    q4.push_back(8'h00);
    @(negedge clk);
    a_valid4 = 1'b0;
    n_tests++;
    if ({y4, y_valid4} !== {8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL disabled: y=%h yv=%b, expected y=00 yv=1", y4, y_valid4);
    end
    en4 = 1'b1;
  endtask

  // Plain scan on H=4, or with a code 6 held alongside start (priority check)
  task automatic test_scan(input bit with_code);
    logic [11:0] exp_v;
    start4 = 1'b1;
    if (with_code) begin
      a4 = 3'd6; a_valid4 = 1'b1; en4 = 1'b1;
    end
    for (int i = 0; i < 8; i++) q4.push_back(8'h01 << i);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (c == 1) start4 = 1'b0;
      if (c <= 32) exp_v = {8'h01 << ((c - 1) / 4), ((c - 1) % 4) == 0, 3'b100};
      else         exp_v = {8'h00, 4'b0011};
      n_tests++;
      if ({y4, y_valid4, busy4, done4, a_ready4} !== exp_v) begin
        n_fail++;
        $display("FAIL scan%0d_c%0d: {y,yv,busy,done,rdy}=%h, expected %h",
                 with_code, c, {y4, y_valid4, busy4, done4, a_ready4}, exp_v);
      end
    end
    // A code still presented in the done cycle is accepted
    if (with_code) begin
      q4.push_back(8'h40);
      @(negedge clk);
      a_valid4 = 1'b0;
      n_tests++;
      if ({y4, y_valid4, busy4} !== {8'h40, 2'b10}) begin
        n_fail++;
        $display("FAIL done_accept: y=%h yv=%b busy=%b, expected y=40 yv=1 busy=0",
                 y4, y_valid4, busy4);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    start4 = 1'b1;
    for (int i = 0; i < 8; i++) q4.push_back(8'h01 << i);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) start4 = 1'b0;
    end
    n_tests++;
    if (y4 !== 8'h08) begin
      n_fail++;
      $display("FAIL mid_pre: y=%h, expected 08", y4);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({y4, y_valid4, busy4, done4, a_ready4} !== {8'h00, 4'b0000}) begin
      n_fail++;
      $display("FAIL mid_reset: {y,yv,busy,done,rdy}=%h, expected %h",
               {y4, y_valid4, busy4, done4, a_ready4}, {8'h00, 4'b0000});
    end
    q4.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    en4 = 1'b1; a4 = 3'd2; a_valid4 = 1'b1;
    q4.push_back(8'h04);
    @(negedge clk);
    a_valid4 = 1'b0;
    n_tests++;
    if ({y4, y_valid4, busy4} !== {8'h04, 2'b10}) begin
      n_fail++;
      $display("FAIL mid_after: y=%h yv=%b busy=%b, expected y=04 yv=1 busy=0",
               y4, y_valid4, busy4);
    end
  endtask

  // H=1: walk on consecutive cycles, then rescan from the done cycle
  task automatic test_back_to_back();
    logic [11:0] exp_v;
    start1 = 1'b1;
    for (int i = 0; i < 8; i++) q1.push_back(8'h01 << i);
    for (int run = 0; run < 2; run++) begin
      for (int c = 1; c <= 9; c++) begin
        @(negedge clk);
        if (c == 1) start1 = 1'b0;
        if (c <= 8) exp_v = {8'h01 << (c - 1), 4'b1100};
        else        exp_v = {8'h00, 4'b0011};
        n_tests++;
        if ({y1, y_valid1, busy1, done1, a_ready1} !== exp_v) begin
          n_fail++;
          $display("FAIL h1_r%0d_c%0d: {y,yv,busy,done,rdy}=%h, expected %h",
                   run, c, {y1, y_valid1, busy1, done1, a_ready1}, exp_v);
        end
        if (c == 9 && run == 0) begin
          start1 = 1'b1;
          for (int i = 0; i < 8; i++) q1.push_back(8'h01 << i);
        end
      end
    end
    @(negedge clk);
    n_tests++;
    if ({y1, y_valid1, busy1, done1} !== {8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL h1_idle: y=%h yv=%b busy=%b done=%b, expected all 0",
               y1, y_valid1, busy1, done1);
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_disabled();
    test_scan(1'b0);
    test_scan(1'b1);
    test_reset_mid_scan();
    test_back_to_back();
    repeat (2) @(negedge clk);
    n_tests++;
    if (q4.size() + q1.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected outputs never seen, expected 0", q4.size() + q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
